// File: rtl/axis_stall_injector.sv
// axis_stall_injector
//
// AXI-Stream stall injector with optional throughput statistics. A single
// register stage sits between upstream and downstream. A 32-bit Galois LFSR
// (mask 32'h8020_0003) decides two things:
//   - random input bubbles that drop s_axis_tready for one cycle
//   - bursty output stalls that hide m_axis_tvalid for 20..51 cycles
// With enable=0 the block is a transparent one-entry register slice.
//
// Optional feature macro: STALL_STATS_EN
//   defined   -> four saturating statistics counters plus stats_clear
//   undefined -> counter outputs tied to zero, stats_clear ignored
//
// Ports:
//   clk, aresetn          clock, asynchronous active-low reset
//   enable                1 = inject bubbles/stalls, 0 = transparent
//   stats_clear           synchronous clear of all statistics counters
//   s_axis_*              upstream AXI-Stream slave (tdata/tvalid/tlast/tready)
//   m_axis_*              downstream AXI-Stream master (tdata/tvalid/tlast/tready)
//   total_cycles          cycles with enable=1
//   in_stall_cycles       cycles with s_axis_tvalid && !s_axis_tready
//   out_beats             downstream handshakes
//   frames                downstream handshakes carrying tlast
module axis_stall_injector #(
  parameter int          DATA_WIDTH       = 48,
  parameter int          IN_BUBBLE_THRESH = 170,
  parameter int          OUT_STALL_THRESH = 6,
  parameter int          STALL_MIN        = 20,
  parameter int          STALL_RANGE_LOG  = 5,
  parameter logic [31:0] LFSR_SEED        = 32'hACE1_2468,
  parameter int          CNT_WIDTH        = 32
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  enable,
  input  logic                  stats_clear,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [CNT_WIDTH-1:0]  total_cycles,
  output logic [CNT_WIDTH-1:0]  in_stall_cycles,
  output logic [CNT_WIDTH-1:0]  out_beats,
  output logic [CNT_WIDTH-1:0]  frames
);

  localparam int          SCNT_W    = 8 + STALL_RANGE_LOG;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [8:0]  BUBBLE_TH = 9'(IN_BUBBLE_THRESH);
  localparam logic [8:0]  STALL_TH  = 9'(OUT_STALL_THRESH);

  typedef enum logic {IDLE, STALL} state_e;

  logic [31:0]           lfsr_q, lfsr_d;
  logic                  rdy_en_q;
  logic                  in_bubble_q, in_bubble_d;
  logic                  full_q, full_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  state_e                state_q, state_d;
  logic [SCNT_W-1:0]     scnt_q, scnt_d;
  logic [SCNT_W-1:0]     stall_len;
  logic                  m_hs, s_hs;

  // Stall length = STALL_MIN plus a random field; a zero-width field is
  // not expressible, so that configuration uses the fixed minimum only.
  generate
    if (STALL_RANGE_LOG == 0) begin : g_fixed_len
      assign stall_len = SCNT_W'(STALL_MIN);
    end else begin : g_rand_len
      assign stall_len = SCNT_W'(STALL_MIN) + SCNT_W'(lfsr_q[16 +: STALL_RANGE_LOG]);
    end
  endgenerate

  assign m_hs          = m_axis_tvalid && m_axis_tready;
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  // Combinational through m_axis_tready so a full stage can accept a new
  // beat in the same cycle it drains.
  assign s_axis_tready = rdy_en_q && !in_bubble_q && (!full_q || m_hs);
  assign m_axis_tvalid = full_q && (state_q == IDLE);
  assign m_axis_tdata  = data_q;
  assign m_axis_tlast  = last_q;

  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ LFSR_MASK;
  end

  assign in_bubble_d = enable && ({1'b0, lfsr_q[7:0]} < BUBBLE_TH);

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    last_d = last_q;
    if (s_hs) begin
      full_d = 1'b1;
      data_d = s_axis_tdata;
      last_d = s_axis_tlast;
    end else if (m_hs) begin
      full_d = 1'b0;
    end
  end

  // A stall may only begin when no valid beat would be withdrawn: either the
  // stage is empty or its beat is handshaking in this very cycle.
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    case (state_q)
      IDLE: begin
        if (enable && ({1'b0, lfsr_q[15:8]} < STALL_TH) && (!full_q || m_hs)) begin
          state_d = STALL;
          scnt_d  = stall_len;
        end
      end
      STALL: begin
        scnt_d = scnt_q - SCNT_W'(1);
        if (!enable || (scnt_q == SCNT_W'(1))) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      lfsr_q      <= LFSR_SEED;
      rdy_en_q    <= 1'b0;
      in_bubble_q <= 1'b0;
      full_q      <= 1'b0;
      data_q      <= '0;
      last_q      <= 1'b0;
      state_q     <= IDLE;
      scnt_q      <= '0;
    end else begin
      lfsr_q      <= lfsr_d;
      rdy_en_q    <= 1'b1;
      in_bubble_q <= in_bubble_d;
      full_q      <= full_d;
      data_q      <= data_d;
      last_q      <= last_d;
      state_q     <= state_d;
      scnt_q      <= scnt_d;
    end
  end

`ifdef STALL_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] total_q, in_stall_q, beats_q, frames_q;

  // Saturating counters; clear wins over any increment in the same cycle.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      total_q    <= '0;
      in_stall_q <= '0;
      beats_q    <= '0;
      frames_q   <= '0;
    end else if (stats_clear) begin
      total_q    <= '0;
      in_stall_q <= '0;
      beats_q    <= '0;
      frames_q   <= '0;
    end else begin
      if (enable && (total_q != '1)) total_q <= total_q + CNT_ONE;
      if (s_axis_tvalid && !s_axis_tready && (in_stall_q != '1)) in_stall_q <= in_stall_q + CNT_ONE;
      if (m_hs && (beats_q != '1)) beats_q <= beats_q + CNT_ONE;
      if (m_hs && last_q && (frames_q != '1)) frames_q <= frames_q + CNT_ONE;
    end
  end

  assign total_cycles    = total_q;
  assign in_stall_cycles = in_stall_q;
  assign out_beats       = beats_q;
  assign frames          = frames_q;
`else
  logic unused_stats_clear;
  assign unused_stats_clear = stats_clear;
  assign total_cycles       = '0;
  assign in_stall_cycles    = '0;
  assign out_beats          = '0;
  assign frames             = '0;
`endif

endmodule

// File: tb/tb_axis_stall_injector.sv
// tb_axis_stall_injector
//
// Self-checking bench for axis_stall_injector: reset values, a table of
// enable=0 cycle vectors, transparent streaming, backpressure hold, random
// injection with a scoreboard, reset during a stall with replay of the LFSR
// pattern, and counter saturation on a CNT_WIDTH=4 instance.
`timescale 1ns/1ps
module tb_axis_stall_injector;

  localparam int DW = 48;
`ifdef STALL_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif
  localparam int SIG_LEN = 400;

  logic          clk = 1'b0;
  logic          aresetn;
  logic          enable;
  logic          statsClear;
  logic [DW-1:0] sData;
  logic          sValid;
  logic          sLast;
  logic          mReady;
  logic          sReady;
  logic [DW-1:0] mData;
  logic          mValid;
  logic          mLast;
  logic [31:0]   totalCycles, inStall, outBeats, frameCount;

  logic          satReadyUnused, satValidUnused, satLastUnused;
  logic [DW-1:0] satDataUnused;
  logic [3:0]    satTotal, satInStall, satBeats, satFrames;

  axis_stall_injector dut (
    .clk(clk), .aresetn(aresetn), .enable(enable), .stats_clear(statsClear),
    .s_axis_tdata(sData), .s_axis_tvalid(sValid), .s_axis_tlast(sLast),
    .s_axis_tready(sReady), .m_axis_tdata(mData), .m_axis_tvalid(mValid),
    .m_axis_tlast(mLast), .m_axis_tready(mReady), .total_cycles(totalCycles),
    .in_stall_cycles(inStall), .out_beats(outBeats), .frames(frameCount)
  );

  axis_stall_injector #(.CNT_WIDTH(4)) dutSat (
    .clk(clk), .aresetn(aresetn), .enable(enable), .stats_clear(statsClear),
    .s_axis_tdata(sData), .s_axis_tvalid(sValid), .s_axis_tlast(sLast),
    .s_axis_tready(satReadyUnused), .m_axis_tdata(satDataUnused),
    .m_axis_tvalid(satValidUnused), .m_axis_tlast(satLastUnused),
    .m_axis_tready(mReady), .total_cycles(satTotal),
    .in_stall_cycles(satInStall), .out_beats(satBeats), .frames(satFrames)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sv;
    logic [7:0] d;
    logic       sl;
    logic       mr;
    logic       expMv;
    logic       expSr;
    logic [7:0] expMd;
    logic       expMl;
  } vec_t;

  vec_t          vecs[10];
  logic [DW:0]   expQ[$];
  int            testsRun = 0;
  int            testsFailed = 0;
  int            popCount = 0;
  int            enCount = 0;
  int            blockRun = 0;
  int            maxBlockRun = 0;
  logic          holdPrev = 1'b0;
  logic [DW:0]   holdBeat;
  logic          sampMv, sampSr, sampSHs;
  logic          sigMv[SIG_LEN];
  logic          sigSr[SIG_LEN];

  // Every comparison goes through here so the counters stay honest.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One clock cycle: inputs are already driven after a falling edge; sample
  // just after that, run the scoreboard and hold check, then wait for the
  // next falling edge (the rising edge happens in between).
  task automatic applyStimulus();
    int pending;
    logic [DW:0] expBeat;
    #1;
    pending = expQ.size();
    sampMv  = mValid;
    sampSr  = sReady;
    sampSHs = sValid && sReady;
    if (holdPrev) begin
      checkOutput("axi_hold_valid", 64'(mValid), 64'd1);
      checkOutput("axi_hold_beat", 64'({mLast, mData}), 64'(holdBeat));
    end
    holdPrev = mValid && !mReady;
    holdBeat = {mLast, mData};
    if (pending > 0 && !mValid) begin
      blockRun++;
    end else begin
      if (blockRun > maxBlockRun) maxBlockRun = blockRun;
      blockRun = 0;
    end
    if (sValid && sReady) expQ.push_back({sLast, sData});
    if (mValid && mReady) begin
      if (expQ.size() == 0) begin
        checkOutput("sb_unexpected_beat", 64'd1, 64'd0);
      end else begin
        expBeat = expQ.pop_front();
        checkOutput("sb_beat", 64'({mLast, mData}), 64'(expBeat));
        popCount++;
      end
    end
    if (enable) enCount++;
    @(negedge clk);
  endtask

  task automatic clearStats();
    statsClear = 1'b1;
    sValid = 1'b0;
    applyStimulus();
    statsClear = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_s_tready"}, 64'(sReady), 64'd0);
    checkOutput({tag, "_m_tvalid"}, 64'(mValid), 64'd0);
    checkOutput({tag, "_m_tdata"}, 64'(mData), 64'd0);
    checkOutput({tag, "_m_tlast"}, 64'(mLast), 64'd0);
  endtask

  initial begin
    #(10 * 90000);
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int beats, ticks, expFrames, startPop, readyCnt, mism;
    logic ratioOk;
    real ratio;

    vecs[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0};
    vecs[2] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0};
    vecs[3] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h22, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0};
    vecs[7] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 1'b1};
    vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0};

    // Reset state, then record a reference run straight out of reset.
    aresetn = 1'b1; enable = 1'b1; statsClear = 1'b0;
    sData = '0; sValid = 1'b1; sLast = 1'b0; mReady = 1'b1;
    #2 aresetn = 1'b0;
    #1;
    checkResetOutputs("reset");
    checkOutput("reset_out_beats", 64'(outBeats), 64'd0);
    checkOutput("reset_total_cycles", 64'(totalCycles), 64'd0);
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    #1;
    checkOutput("release_s_tready_low", 64'(sReady), 64'd0);
    for (int i = 0; i < SIG_LEN; i++) begin
      sData = DW'(i + 1);
      applyStimulus();
      sigMv[i] = sampMv;
      sigSr[i] = sampSr;
    end

    // Table of enable=0 cycles starting from an empty stage.
    enable = 1'b0; sValid = 1'b0; mReady = 1'b1;
    repeat (3) applyStimulus();
    for (int i = 0; i < 10; i++) begin
      sValid = vecs[i].sv;
      sData  = DW'(vecs[i].d);
      sLast  = vecs[i].sl;
      mReady = vecs[i].mr;
      #1;
      checkOutput($sformatf("vec%0d_m_tvalid", i), 64'(mValid), 64'(vecs[i].expMv));
      checkOutput($sformatf("vec%0d_s_tready", i), 64'(sReady), 64'(vecs[i].expSr));
      if (vecs[i].expMv) begin
        checkOutput($sformatf("vec%0d_m_tdata", i), 64'(mData), 64'(vecs[i].expMd));
        checkOutput($sformatf("vec%0d_m_tlast", i), 64'(mLast), 64'(vecs[i].expMl));
      end
      applyStimulus();
    end

    // Transparent streaming of 100 beats, plus saturation on the small instance.
    sValid = 1'b0; sLast = 1'b0; mReady = 1'b1;
    clearStats();
    startPop = popCount;
    readyCnt = 0;
    for (int i = 0; i < 100; i++) begin
      sValid = 1'b1;
      sData  = DW'(i);
      sLast  = (i == 99);
      applyStimulus();
      if (sampSr) readyCnt++;
    end
    sValid = 1'b0; sLast = 1'b0;
    applyStimulus();
    checkOutput("transparent_ready_cycles", 64'(readyCnt), 64'd100);
    checkOutput("transparent_beats_out", 64'(popCount - startPop), 64'd100);
    checkOutput("transparent_out_beats", 64'(outBeats), STATS_ON ? 64'd100 : 64'd0);
    checkOutput("transparent_frames", 64'(frameCount), STATS_ON ? 64'd1 : 64'd0);
    checkOutput("transparent_total_cycles", 64'(totalCycles), 64'd0);
    checkOutput("transparent_in_stall", 64'(inStall), 64'd0);
    checkOutput("sat_out_beats", 64'(satBeats), STATS_ON ? 64'd15 : 64'd0);
    checkOutput("sat_frames", 64'(satFrames), STATS_ON ? 64'd1 : 64'd0);
    clearStats();
    checkOutput("clear_sat_out_beats", 64'(satBeats), 64'd0);
    checkOutput("clear_sat_frames", 64'(satFrames), 64'd0);
    checkOutput("clear_sat_in_stall", 64'(satInStall), 64'd0);
    checkOutput("clear_sat_total", 64'(satTotal), 64'd0);
    checkOutput("clear_out_beats", 64'(outBeats), 64'd0);
    checkOutput("clear_frames", 64'(frameCount), 64'd0);

    // Backpressure hold with a pending beat and upstream kept valid.
    clearStats();
    sValid = 1'b1; sData = DW'(48'hBEEF); mReady = 1'b1;
    applyStimulus();
    sData = DW'(48'hCAFE); mReady = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      checkOutput($sformatf("hold%0d_s_tready", i), 64'(sampSr), 64'd0);
      checkOutput($sformatf("hold%0d_m_tvalid", i), 64'(sampMv), 64'd1);
    end
    checkOutput("hold_m_tdata", 64'(mData), 64'hBEEF);
    checkOutput("hold_in_stall_cycles", 64'(inStall), STATS_ON ? 64'd10 : 64'd0);
    sValid = 1'b0; mReady = 1'b1;
    repeat (2) applyStimulus();

    // Random injection: 2000 beats with ready high, 500 with random ready.
    clearStats();
    enCount = 0; maxBlockRun = 0; blockRun = 0;
    startPop = popCount; expFrames = 0;
    enable = 1'b1;
    beats = 0; ticks = 0;
    while (beats < 2500 && ticks < 40000) begin
      sValid = 1'b1;
      sData  = DW'({$urandom(), $urandom()});
      sLast  = (beats % 100 == 99);
      mReady = (beats < 2000) ? 1'b1 : 1'($urandom_range(0, 1));
      applyStimulus();
      if (sampSHs) begin
        beats++;
        if (sLast) expFrames++;
      end
      ticks++;
    end
    checkOutput("inject_beats_accepted", 64'(beats), 64'd2500);
    sValid = 1'b0; sLast = 1'b0; mReady = 1'b1; enable = 1'b0;
    ticks = 0;
    while (expQ.size() != 0 && ticks < 200) begin
      applyStimulus();
      ticks++;
    end
    applyStimulus();
    checkOutput("inject_drained", 64'(expQ.size()), 64'd0);
    checkOutput("inject_beats_out", 64'(popCount - startPop), 64'd2500);
    checkOutput("inject_out_beats", 64'(outBeats), STATS_ON ? 64'd2500 : 64'd0);
    checkOutput("inject_frames", 64'(frameCount), STATS_ON ? 64'(expFrames) : 64'd0);
    checkOutput("inject_total_cycles", 64'(totalCycles), STATS_ON ? 64'(enCount) : 64'd0);
    // Bubbles alone block about 2/3 of enabled cycles; stalls add to that.
    ratio = (totalCycles != 0) ? real'(inStall) / real'(totalCycles) : 0.0;
    ratioOk = STATS_ON ? (totalCycles != 0 && ratio >= 0.55 && ratio <= 0.95)
                       : (inStall == 0 && totalCycles == 0);
    checkOutput("inject_stall_ratio", 64'(ratioOk), 64'd1);
    checkOutput("stall_burst_max_le_51", 64'(maxBlockRun <= 51), 64'd1);
    checkOutput("stall_burst_seen_ge_20", 64'(maxBlockRun >= 20), 64'd1);

    // Reset while a stall holds a full stage, then replay the reference run.
    enable = 1'b1; sValid = 1'b1; mReady = 1'b1;
    ticks = 0;
    mism = 1;
    while (ticks < 3000) begin
      sData = DW'(ticks + 7);
      applyStimulus();
      #2;
      if (!mValid && expQ.size() > 0) begin
        mism = 0;
        break;
      end
      ticks++;
    end
    checkOutput("stall_found_for_reset", 64'(mism), 64'd0);
    aresetn = 1'b0;
    #1;
    checkResetOutputs("midstall_reset");
    expQ.delete();
    holdPrev = 1'b0;
    blockRun = 0;
    repeat (2) @(negedge clk);
    sData = '0; sLast = 1'b0;
    aresetn = 1'b1;
    #1;
    checkOutput("rerelease_s_tready_low", 64'(sReady), 64'd0);
    mism = 0;
    for (int i = 0; i < SIG_LEN; i++) begin
      sData = DW'(i + 1);
      applyStimulus();
      if (sampMv !== sigMv[i] || sampSr !== sigSr[i]) mism++;
    end
    checkOutput("replay_pattern_mismatches", 64'(mism), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
